// File: rtl/parc_core_reorder_buffer.sv
// parc_core_reorder_buffer
// 16-entry in-order reorder buffer for the PARC core. Decode allocates a
// slot at the tail, writeback fills slots in any order, and the head entry
// retires to the register file once its result has arrived. Stored results
// can be read back by slot ID for operand bypass.
//
// Handshakes:
//   alloc  - rob_alloc_rdy is a pure function of occupancy (count < 16) and
//            never looks at a same-cycle commit. An allocation fires on a
//            rising edge when rob_alloc_req && rob_alloc_rdy. A request while
//            full is dropped and the requester must hold it until rdy returns.
//   fill   - rob_fill_val is a one-cycle strobe with no back-pressure; it is
//            accepted only if the addressed slot is valid and still pending,
//            otherwise it is silently dropped.
//   commit - rob_commit_wen is a one-cycle strobe with no back-pressure; the
//            head entry retires on the edge that ends the cycle it is high.
module parc_core_reorder_buffer #(
    parameter int NUM_ENTRIES = 16,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    // allocate from decode
    input  logic              rob_alloc_req,
    input  logic [4:0]        rob_alloc_dst,
    output logic              rob_alloc_rdy,
    output logic [3:0]        rob_alloc_slot,
    // writeback
    input  logic              rob_fill_val,
    input  logic [3:0]        rob_fill_slot,
    input  logic [DATA_W-1:0] rob_fill_data,
    // retire to register file
    output logic              rob_commit_wen,
    output logic [3:0]        rob_commit_slot,
    output logic [4:0]        rob_commit_rf_waddr,
    output logic [DATA_W-1:0] rob_commit_rf_wdata,
    // operand bypass reads
    input  logic [3:0]        rob_byp_slot0,
    input  logic [3:0]        rob_byp_slot1,
    output logic [DATA_W-1:0] rob_byp_data0,
    output logic [DATA_W-1:0] rob_byp_data1
);

    // Occupancy value that means "every slot in use".
    localparam logic [4:0] FULL_COUNT = 5'(NUM_ENTRIES);

    // Per-entry state.
    logic [NUM_ENTRIES-1:0] valid_q,   valid_d;
    logic [NUM_ENTRIES-1:0] pending_q, pending_d;
    logic [4:0]             dst_q      [NUM_ENTRIES];
    logic [4:0]             dst_d      [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_q     [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_d     [NUM_ENTRIES];

    // Circular-buffer bookkeeping. head == tail is ambiguous on its own;
    // count tells empty (0) from full (16).
    logic [3:0] head_q,  head_d;
    logic [3:0] tail_q,  tail_d;
    logic [4:0] count_q, count_d;

    logic alloc_fire;
    logic fill_fire;
    logic commit_fire;

    // Event decode: which of allocate / fill / commit happen at the next edge.
    always_comb begin
        rob_alloc_rdy = (count_q < FULL_COUNT);
        alloc_fire    = rob_alloc_req && rob_alloc_rdy;
        // A slot being allocated this cycle is still invalid, so a fill that
        // targets it is dropped by the valid check alone.
        fill_fire     = rob_fill_val && valid_q[rob_fill_slot] && pending_q[rob_fill_slot];
        commit_fire   = valid_q[head_q] && !pending_q[head_q];
    end

    // Next-state for the entry array. The three events never touch the same
    // field of the same slot: alloc only hits an invalid slot, fill only a
    // pending one, commit only a non-pending one.
    always_comb begin
        valid_d   = valid_q;
        pending_d = pending_q;
        dst_d     = dst_q;
        data_d    = data_q;
        if (alloc_fire) begin
            valid_d[tail_q]   = 1'b1;
            pending_d[tail_q] = 1'b1;
            dst_d[tail_q]     = rob_alloc_dst;
        end
        if (fill_fire) begin
            pending_d[rob_fill_slot] = 1'b0;
            data_d[rob_fill_slot]    = rob_fill_data;
        end
        if (commit_fire) begin
            valid_d[head_q] = 1'b0;
        end
    end

    // Next-state for the pointers and occupancy; 4-bit pointers wrap 15 -> 0.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (alloc_fire) begin
            tail_d = tail_q + 4'd1;
        end
        if (commit_fire) begin
            head_d = head_q + 4'd1;
        end
        case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset clears everything, including stored data, so the
    // bypass and commit data outputs read zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= '0;
            pending_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                dst_q[i]  <= '0;
                data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            pending_q <= pending_d;
            dst_q     <= dst_d;
            data_q    <= data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Output views of the state. Commit fields always show the head entry;
    // they only mean something while rob_commit_wen is high. Bypass reads are
    // raw storage and do not see a fill landing in the same cycle.
    always_comb begin
        rob_alloc_slot      = tail_q;
        rob_commit_wen      = commit_fire;
        rob_commit_slot     = head_q;
        rob_commit_rf_waddr = dst_q[head_q];
        rob_commit_rf_wdata = data_q[head_q];
        rob_byp_data0       = data_q[rob_byp_slot0];
        rob_byp_data1       = data_q[rob_byp_slot1];
    end

endmodule

// File: tb/tb_parc_core_reorder_buffer.sv
// tb_parc_core_reorder_buffer
// Directed and randomized stimulus for the reorder buffer. The reference is
// an ordered list of in-flight instructions plus a per-slot copy of the last
// written result; expected retirements are queued and checked by a monitor.
module tb_parc_core_reorder_buffer;

    localparam int DATA_W = 32;
    localparam int EW     = 4 + 5 + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic              rob_alloc_req = 1'b0;
    logic [4:0]        rob_alloc_dst = '0;
    logic              rob_alloc_rdy;
    logic [3:0]        rob_alloc_slot;
    logic              rob_fill_val = 1'b0;
    logic [3:0]        rob_fill_slot = '0;
    logic [DATA_W-1:0] rob_fill_data = '0;
    logic              rob_commit_wen;
    logic [3:0]        rob_commit_slot;
    logic [4:0]        rob_commit_rf_waddr;
    logic [DATA_W-1:0] rob_commit_rf_wdata;
    logic [3:0]        rob_byp_slot0 = '0;
    logic [3:0]        rob_byp_slot1 = '0;
    logic [DATA_W-1:0] rob_byp_data0;
    logic [DATA_W-1:0] rob_byp_data1;

    parc_core_reorder_buffer #(.NUM_ENTRIES(16), .DATA_W(DATA_W)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .rob_alloc_req       (rob_alloc_req),
        .rob_alloc_dst       (rob_alloc_dst),
        .rob_alloc_rdy       (rob_alloc_rdy),
        .rob_alloc_slot      (rob_alloc_slot),
        .rob_fill_val        (rob_fill_val),
        .rob_fill_slot       (rob_fill_slot),
        .rob_fill_data       (rob_fill_data),
        .rob_commit_wen      (rob_commit_wen),
        .rob_commit_slot     (rob_commit_slot),
        .rob_commit_rf_waddr (rob_commit_rf_waddr),
        .rob_commit_rf_wdata (rob_commit_rf_wdata),
        .rob_byp_slot0       (rob_byp_slot0),
        .rob_byp_slot1       (rob_byp_slot1),
        .rob_byp_data0       (rob_byp_data0),
        .rob_byp_data1       (rob_byp_data1)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]        slot;
        logic [4:0]        dst;
        bit                filled;
        logic [DATA_W-1:0] data;
    } inst_t;

    inst_t             m_q[$];          // in-flight instructions, oldest first
    int                m_tail;          // next slot handed out
    logic [DATA_W-1:0] mem_data [16];   // last result written into each slot

    logic [EW-1:0] exp_q[$];            // expected {slot, waddr, wdata} commits
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_q.delete();
        m_tail = 0;
        for (int i = 0; i < 16; i++) mem_data[i] = '0;
        exp_q.delete();
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle: drive inputs at the falling edge, check the
    // combinational outputs, then advance the model at the rising edge.
    task automatic cycle(input bit a_req, input logic [4:0] a_dst,
                         input bit f_val, input logic [3:0] f_slot,
                         input logic [DATA_W-1:0] f_data,
                         input logic [3:0] b0, input logic [3:0] b1);
        int sz;
        int head;
        bit will_commit;
        @(negedge clk);
        rob_alloc_req = a_req;
        rob_alloc_dst = a_dst;
        rob_fill_val  = f_val;
        rob_fill_slot = f_slot;
        rob_fill_data = f_data;
        rob_byp_slot0 = b0;
        rob_byp_slot1 = b1;
        sz   = m_q.size();
        head = (m_tail + 16 - sz) % 16;
        will_commit = (sz > 0) && m_q[0].filled;
        if (will_commit) exp_q.push_back({m_q[0].slot, m_q[0].dst, m_q[0].data});
        #1;
        chk("alloc_rdy", 64'(rob_alloc_rdy), 64'(sz < 16));
        if (sz < 16) chk("alloc_slot", 64'(rob_alloc_slot), 64'(m_tail));
        chk("commit_slot", 64'(rob_commit_slot), 64'(head));
        chk("byp_data0", 64'(rob_byp_data0), 64'(mem_data[b0]));
        chk("byp_data1", 64'(rob_byp_data1), 64'(mem_data[b1]));
        @(posedge clk);
        if (f_val) begin
            foreach (m_q[i]) begin
                if (m_q[i].slot == f_slot && !m_q[i].filled) begin
                    m_q[i].filled = 1'b1;
                    m_q[i].data   = f_data;
                    mem_data[f_slot] = f_data;
                end
            end
        end
        if (will_commit) void'(m_q.pop_front());
        if (a_req && sz < 16) begin
            m_q.push_back('{slot: 4'(m_tail), dst: a_dst, filled: 1'b0, data: '0});
            m_tail = (m_tail + 1) % 16;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 1'b0, 4'd0, '0, 4'd0, 4'd0);
    endtask

    task automatic alloc(input logic [4:0] dst);
        cycle(1'b1, dst, 1'b0, 4'd0, '0, 4'd0, 4'd0);
    endtask

    task automatic fill(input logic [3:0] slot, input logic [DATA_W-1:0] data);
        cycle(1'b0, 5'd0, 1'b1, slot, data, slot, 4'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_alloc_rdy"},  64'(rob_alloc_rdy), 64'd1);
        chk({tag, "_alloc_slot"}, 64'(rob_alloc_slot), 64'd0);
        chk({tag, "_commit_wen"}, 64'(rob_commit_wen), 64'd0);
        chk({tag, "_commit_slot"}, 64'(rob_commit_slot), 64'd0);
        chk({tag, "_rf_waddr"},   64'(rob_commit_rf_waddr), 64'd0);
        chk({tag, "_rf_wdata"},   64'(rob_commit_rf_wdata), 64'd0);
        chk({tag, "_byp_data0"},  64'(rob_byp_data0), 64'd0);
        chk({tag, "_byp_data1"},  64'(rob_byp_data1), 64'd0);
    endtask

    // Assert reset between clock edges, check outputs before any edge, hold
    // across one edge, then release so the next edge can allocate.
    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rob_alloc_req = 1'b0;
        rob_fill_val  = 1'b0;
        rob_byp_slot0 = 4'd7;
        rob_byp_slot1 = 4'd13;
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        model_clear();
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    // Fill outstanding entries oldest-first until everything has retired.
    task automatic drain();
        for (int n = 0; n < 48; n++) begin
            int pick;
            if (m_q.size() == 0) break;
            pick = -1;
            foreach (m_q[i]) if (pick < 0 && !m_q[i].filled) pick = i;
            if (pick >= 0) fill(m_q[pick].slot, $urandom());
            else idle();
        end
        idle();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                got = {rob_commit_slot, rob_commit_rf_waddr, rob_commit_rf_wdata};
                if (rob_commit_wen) begin
                    if (exp_q.size() == 0) begin
                        chk("commit_unexpected", 64'(got), 64'd0 - 64'd1);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("commit", 64'(got), 64'(exp));
                    end
                end else if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    chk("commit_missing", 64'(rob_commit_wen), 64'd1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        do_reset();

        // single instruction round trip
        alloc(5'd5);
        fill(4'd0, 32'hDEADBEEF);
        idle();
        idle();

        // out-of-order fills retire in allocation order
        do_reset();
        alloc(5'd1);
        alloc(5'd2);
        alloc(5'd3);
        fill(4'd2, 32'h0000_2222);
        idle();
        fill(4'd0, 32'h0000_0000);
        fill(4'd1, 32'h1111_1111);
        idle();
        idle();
        idle();

        // fill the buffer, request while full, retire head while requesting
        do_reset();
        for (int i = 0; i < 16; i++) alloc(5'(i));
        cycle(1'b1, 5'd20, 1'b1, 4'd0, 32'hA5A5_0000, 4'd0, 4'd15);
        cycle(1'b1, 5'd21, 1'b0, 4'd0, '0, 4'd0, 4'd1);
        cycle(1'b1, 5'd22, 1'b0, 4'd0, '0, 4'd0, 4'd1);
        idle();
        drain();

        // fill to an unallocated slot is dropped
        do_reset();
        cycle(1'b0, 5'd0, 1'b1, 4'd7, 32'h0000_1234, 4'd7, 4'd7);
        cycle(1'b0, 5'd0, 1'b0, 4'd0, '0, 4'd7, 4'd0);
        idle();

        // reset mid-operation: 4 pending, 2 of them filled behind the head
        for (int i = 0; i < 4; i++) alloc(5'(10 + i));
        fill(4'd2, 32'hCAFE_0002);
        fill(4'd3, 32'hCAFE_0003);
        do_reset();
        alloc(5'd9);
        idle();
        drain();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit         a_req;
            bit         f_val;
            logic [3:0] f_slot;
            int         pend[$];
            if (i == 500 || i == 1000) do_reset();
            a_req  = ($urandom_range(0, 9) < 7);
            f_val  = ($urandom_range(0, 9) < 6);
            f_slot = 4'($urandom_range(0, 15));
            foreach (m_q[k]) if (!m_q[k].filled) pend.push_back(k);
            if (pend.size() > 0 && $urandom_range(0, 9) < 8)
                f_slot = m_q[pend[$urandom_range(0, pend.size() - 1)]].slot;
            cycle(a_req, 5'($urandom_range(0, 31)), f_val, f_slot, $urandom(),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parc_core_reorder_buffer.md
PARC_CORE_REORDER_BUFFER -- requirements
Module: parc_core_reorder_buffer

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 16: ROB depth; fixed at 16 for PARC; 4-bit slot IDs.
REQ-002 The block SHALL have parameter DATA_W, default 32: writeback data width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rob_alloc_req  input  1  decode requests a slot (scoreboard accept with dst_en).
REQ-006 rob_alloc_dst  input  5  architectural destination register of allocating instruction.
REQ-007 rob_alloc_rdy  output  1  a free slot exists.
REQ-008 rob_alloc_slot  output  4  slot granted this cycle (current tail).
REQ-009 rob_fill_val  input  1  writeback result valid.
REQ-010 rob_fill_slot  input  4  slot being written back.
REQ-011 rob_fill_data  input  DATA_W  writeback result.
REQ-012 rob_commit_wen  output  1  head entry retires this cycle.
REQ-013 rob_commit_slot  output  4  slot retiring (current head).
REQ-014 rob_commit_rf_waddr  output  5  register-file write address of retiring entry.
REQ-015 rob_commit_rf_wdata  output  DATA_W  register-file write data of retiring entry.
REQ-016 rob_byp_slot0 / rob_byp_slot1  input  4 each  bypass read slot IDs (from scoreboard src0/src1_byp_rob_slot).
REQ-017 rob_byp_data0 / rob_byp_data1  output  DATA_W each  stored data of addressed slot.

Function
REQ-018 Per-entry state SHALL be: valid, pending, dst[4:0], data[DATA_W-1:0]; plus head[3:0], tail[3:0], count[4:0].
REQ-019 rob_alloc_rdy SHALL be combinational: 1 iff count < 16; it SHALL NOT depend on a same-cycle commit.
REQ-020 rob_alloc_slot SHALL equal tail combinationally, valid whenever rob_alloc_rdy=1.
REQ-021 Allocation fires when rob_alloc_req && rob_alloc_rdy; at next edge entry[tail] gets valid=1, pending=1, dst=rob_alloc_dst; tail increments mod 16.
REQ-022 rob_alloc_req while full SHALL be ignored (no state change); the requester is responsible for stalling.
REQ-023 Fill: when rob_fill_val and entry[rob_fill_slot] is valid and pending, at next edge pending clears and data=rob_fill_data.
REQ-024 Fill to an invalid or non-pending slot SHALL be ignored; this includes a slot being allocated in the same cycle.
REQ-025 rob_commit_wen SHALL be combinational: 1 iff entry[head].valid && !entry[head].pending.
REQ-026 When rob_commit_wen=1: commit_slot=head, rf_waddr=entry[head].dst, rf_wdata=entry[head].data; at next edge entry[head].valid clears and head increments mod 16.
REQ-027 When rob_commit_wen=0, commit_slot SHALL still equal head; rf_waddr and rf_wdata reflect the head entry, but consumers SHALL ignore them.
REQ-028 Commit SHALL be strictly in allocation order, at most one per cycle; minimum fill-to-commit latency is 1 cycle (fill at edge N, commit_wen high in cycle after N).
REQ-029 Commit to dst=0 SHALL assert rob_commit_wen normally; the register file discards r0 writes.
REQ-030 Count update: +1 on allocate only, -1 on commit only, unchanged on both or neither; count never exceeds 16 or underflows.
REQ-031 Pointer wrap: slot 15 increments to slot 0 for both head and tail; full is count=16 with head==tail, empty is count=0 with head==tail.
REQ-032 Bypass reads SHALL be combinational from entry data with no valid/pending qualification; a same-cycle fill is not forwarded.

Reset
REQ-033 Asserting reset_n low SHALL immediately clear all valid/pending bits, dst and data to 0, and head, tail and count to 0, including mid-operation.
REQ-034 During and after reset: rob_alloc_rdy=1, rob_alloc_slot=0, rob_commit_wen=0, rob_commit_slot=0, rf_waddr=0, rf_wdata=0, byp_data=0.
REQ-035 Reset release SHALL allow allocation in the first clock edge after reset_n rises.

Verification
REQ-036 Reset, alloc dst=5, fill slot 0 data 0xDEADBEEF next cycle -> one cycle later commit_wen=1, slot=0, waddr=5, wdata=0xDEADBEEF; then empty.
REQ-037 Alloc slots 0,1,2 (dst 1,2,3); fill in order 2,0,1 -> commits occur in order 0,1,2 only, commit_wen=0 until slot 0 is filled.
REQ-038 16 allocations without fills -> rob_alloc_rdy=0 after 16th; 17th request ignored; fill+commit slot 0 -> rdy=1 next cycle, alloc_slot=0 (wrap).
REQ-039 Full buffer with head committing and alloc_req high same cycle -> no allocation that cycle; count 16->15; allocation succeeds next cycle.
REQ-040 Fill to unallocated slot 7 with data 0x1234 -> no state change; byp_slot0=7 returns 0.
REQ-041 Pull reset_n low with 4 entries pending and 2 filled -> all outputs at reset values immediately, without a clock edge; subsequent alloc returns slot 0.
